// File: rtl/canvas_pkg.sv
// rtl/canvas_pkg.sv - shared constants, state encoding and cell addressing for the canvas arbiter
// Contents:
//   GRID, IDX_W, CELLS, CELL_W, LAST_IDX  canvas geometry
//   state_t                               arbiter FSM encoding (IDLE, CLEAR, READ)
//   cell_idx(x, y)                        flat bit index of cell (x,y) = x*GRID + y
package canvas_pkg;

  localparam int GRID   = 32;
  localparam int IDX_W  = 5;
  localparam int CELLS  = GRID * GRID;
  localparam int CELL_W = 2 * IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(GRID - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    READ  = 2'd2
  } state_t;

  // Column-major layout: one column occupies GRID consecutive bits, so a
  // column is a single aligned part-select.
  function automatic logic [CELL_W-1:0] cell_idx(input logic [IDX_W-1:0] x,
                                                 input logic [IDX_W-1:0] y);
    return CELL_W'(x) * CELL_W'(GRID) + CELL_W'(y);
  endfunction

endpackage

// File: rtl/canvas_brush.sv
// rtl/canvas_brush.sv - combinational brush footprint: write mask and value with edge clipping
// Ports:
//   cx, cy    in   brush centre column / row
//   erase     in   1 = brush clears cells, 0 = brush sets cells
//   wr_mask   out  one bit per canvas cell touched by the brush
//   wr_val    out  value to write into the masked cells
module canvas_brush
  import canvas_pkg::*;
#(
  parameter bit BRUSH_PLUS = 1'b1
) (
  input  logic [IDX_W-1:0] cx,
  input  logic [IDX_W-1:0] cy,
  input  logic             erase,
  output logic [CELLS-1:0] wr_mask,
  output logic [CELLS-1:0] wr_val
);

  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  always_comb begin
    wr_mask = '0;
    wr_mask[cell_idx(cx, cy)] = 1'b1;
    if (BRUSH_PLUS) begin
      // Neighbours beyond an edge are dropped rather than wrapped.
      if (cx != '0)       wr_mask[cell_idx(cx - ONE, cy)] = 1'b1;
      if (cx != LAST_IDX) wr_mask[cell_idx(cx + ONE, cy)] = 1'b1;
      if (cy != '0)       wr_mask[cell_idx(cx, cy - ONE)] = 1'b1;
      if (cy != LAST_IDX) wr_mask[cell_idx(cx, cy + ONE)] = 1'b1;
    end
  end

  assign wr_val = erase ? '0 : wr_mask;

endmodule

// File: rtl/canvas_arbiter.sv
// rtl/canvas_arbiter.sv - owns the 32x32 canvas; arbitrates paint, clear and column readout
// Ports:
//   clkVga, iRstN                          pixel clock, async active-low reset
//   iPaintReq/iPaintErase/iPaintX/iPaintY  brush request (level, held until oPaintAck)
//   oPaintAck                              combinational grant, write commits this edge
//   iClearReq, iReadStart                  single-cycle operation requests
//   oColData/oColIdx/oColValid/iColReady   column-serial readout stream
//   oReadDone                              one-cycle pulse after the last column is taken
//   oBusy                                  not IDLE or an operation pending
//   iPixX/iPixY -> oPixOn                  registered VGA cell lookup
//   oImage                                 flat canvas, bit x*32+y
module canvas_arbiter
  import canvas_pkg::*;
#(
  parameter bit BRUSH_PLUS = 1'b1
) (
  input  logic             clkVga,
  input  logic             iRstN,
  input  logic             iPaintReq,
  input  logic             iPaintErase,
  input  logic [IDX_W-1:0] iPaintX,
  input  logic [IDX_W-1:0] iPaintY,
  output logic             oPaintAck,
  input  logic             iClearReq,
  input  logic             iReadStart,
  output logic [GRID-1:0]  oColData,
  output logic [IDX_W-1:0] oColIdx,
  output logic             oColValid,
  input  logic             iColReady,
  output logic             oReadDone,
  output logic             oBusy,
  input  logic [IDX_W-1:0] iPixX,
  input  logic [IDX_W-1:0] iPixY,
  output logic             oPixOn,
  output logic [CELLS-1:0] oImage
);

  logic [CELLS-1:0] canvas;
  logic [CELLS-1:0] brush_mask;
  logic [CELLS-1:0] brush_val;

  state_t           state, state_n;
  logic [IDX_W-1:0] cnt, cnt_n;
  logic             clr_pend, clr_pend_n;
  logic             rd_pend, rd_pend_n;
  logic             col_valid_n;
  logic             read_done_n;
  logic             col_load;

  canvas_brush #(.BRUSH_PLUS(BRUSH_PLUS)) u_brush (
    .cx      (iPaintX),
    .cy      (iPaintY),
    .erase   (iPaintErase),
    .wr_mask (brush_mask),
    .wr_val  (brush_val)
  );

  // Paint only when nothing else wants the canvas, so a readout snapshot
  // can never be disturbed mid-stream.
  assign oPaintAck = iPaintReq && (state == IDLE) && !clr_pend && !rd_pend
                     && !iClearReq && !iReadStart;
  assign oBusy     = (state != IDLE) || clr_pend || rd_pend;
  assign oImage    = canvas;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    clr_pend_n  = clr_pend | iClearReq;
    rd_pend_n   = rd_pend | iReadStart;
    col_valid_n = oColValid;
    read_done_n = 1'b0;
    col_load    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_pend || iClearReq) begin
          state_n    = CLEAR;
          cnt_n      = '0;
          clr_pend_n = 1'b0;
        end else if (rd_pend || iReadStart) begin
          state_n     = READ;
          cnt_n       = '0;
          rd_pend_n   = 1'b0;
          col_valid_n = 1'b1;
          col_load    = 1'b1;
        end
      end
      CLEAR: begin
        cnt_n = cnt + IDX_W'(1);
        if (cnt == LAST_IDX) begin
          if (rd_pend) begin
            state_n     = READ;
            cnt_n       = '0;
            rd_pend_n   = 1'b0;
            col_valid_n = 1'b1;
            col_load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      READ: begin
        if (oColValid && iColReady) begin
          if (cnt == LAST_IDX) begin
            col_valid_n = 1'b0;
            read_done_n = 1'b1;
            if (clr_pend) begin
              state_n    = CLEAR;
              cnt_n      = '0;
              clr_pend_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n    = cnt + IDX_W'(1);
            col_load = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      state     <= IDLE;
      cnt       <= '0;
      clr_pend  <= 1'b0;
      rd_pend   <= 1'b0;
      oColValid <= 1'b0;
      oColData  <= '0;
      oColIdx   <= '0;
      oReadDone <= 1'b0;
      oPixOn    <= 1'b0;
      canvas    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      clr_pend  <= clr_pend_n;
      rd_pend   <= rd_pend_n;
      oColValid <= col_valid_n;
      oReadDone <= read_done_n;
      oPixOn    <= canvas[cell_idx(iPixX, iPixY)];
      // Words only change on load, which keeps them stable under backpressure.
      if (col_load) begin
        oColData <= canvas[cell_idx(cnt_n, '0) +: GRID];
        oColIdx  <= cnt_n;
      end
      if (state == CLEAR) begin
        canvas[cell_idx(cnt, '0) +: GRID] <= '0;
      end else if (oPaintAck) begin
        canvas <= (canvas & ~brush_mask) | (brush_val & brush_mask);
      end
    end
  end

endmodule
